storage_bank_sequencer: RTL and testbench

Controller that sequences a 4-slot, 8-bit storage bank from three push-buttons (write, transfer, scan) and the 8 slide switches. The bank behaves as a FIFO. Write pushes the switch value, transfer pops the oldest entry to the green LEDs, and scan mode cycles the green LEDs through the stored entries without popping. It sits at board top level in place of a single storage register. HEX0/HEX1 are driven through the shared seven_segment_display decoder.

---
 rtl/storage_bank_sequencer_pkg.sv | 37 +++
 rtl/storage_bank_sequencer_if.sv | 28 ++
 rtl/seven_segment_display.sv | 31 +++
 rtl/storage_bank_sequencer_button_pulse.sv | 35 +++
 rtl/storage_bank_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_storage_bank_sequencer.sv | 223 ++++++++++++++++++++++
 6 files changed

// File: rtl/storage_bank_sequencer_pkg.sv
// Shared definitions for the storage bank sequencer: FSM encoding,
// status LED bit positions and pointer/count width helpers.
package storage_bank_sequencer_pkg;

  // Board-level bus widths
  localparam int LED_W    = 8;
  localparam int STATUS_W = 4;
  localparam int HEX_W    = 7;

  // Bit positions inside status_leds
  localparam int STATUS_ERR   = 3;
  localparam int STATUS_SCAN  = 2;
  localparam int STATUS_FULL  = 1;
  localparam int STATUS_EMPTY = 0;

  // Sequencer states
  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_SCAN_SHOW = 1'b1
  } seq_state_e;

  // Pointer width for a bank of the given depth (depth is a power of two)
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy counter width: one extra bit so that "full" is representable
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Timer width for a scan period of at least 2 cycles
  function automatic int timer_width(input int period);
    return (period > 2) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/storage_bank_sequencer_if.sv
// Board-facing bus of the storage bank sequencer: switches and buttons in,
// LEDs and seven-segment digits out.
interface storage_bank_sequencer_if;
  import storage_bank_sequencer_pkg::*;

  logic [LED_W-1:0]    switches;
  logic                write_button;
  logic                transfer_button;
  logic                scan_button;
  logic [LED_W-1:0]    red_leds;
  logic [LED_W-1:0]    green_leds;
  logic [STATUS_W-1:0] status_leds;
  logic [HEX_W-1:0]    HEX0;
  logic [HEX_W-1:0]    HEX1;

  // Board side: drives switches and buttons, observes the displays
  modport master (
    output switches, write_button, transfer_button, scan_button,
    input  red_leds, green_leds, status_leds, HEX0, HEX1
  );

  // Sequencer side
  modport slave (
    input  switches, write_button, transfer_button, scan_button,
    output red_leds, green_leds, status_leds, HEX0, HEX1
  );

endinterface

// File: rtl/seven_segment_display.sv
// Hex nibble to seven-segment decoder, active-low segments ordered {g,f,e,d,c,b,a}.
module seven_segment_display (
  input  logic [3:0] value,
  output logic [6:0] segments
);

  // Pure lookup from nibble to segment pattern
  always_comb begin
    segments = 7'b1111111;
    case (value)
      4'h0:    segments = 7'b1000000;
      4'h1:    segments = 7'b1111001;
      4'h2:    segments = 7'b0100100;
      4'h3:    segments = 7'b0110000;
      4'h4:    segments = 7'b0011001;
      4'h5:    segments = 7'b0010010;
      4'h6:    segments = 7'b0000010;
      4'h7:    segments = 7'b1111000;
      4'h8:    segments = 7'b0000000;
      4'h9:    segments = 7'b0010000;
      4'hA:    segments = 7'b0001000;
      4'hB:    segments = 7'b0000011;
      4'hC:    segments = 7'b1000110;
      4'hD:    segments = 7'b0100001;
      4'hE:    segments = 7'b0000110;
      4'hF:    segments = 7'b0001110;
      default: segments = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/storage_bank_sequencer_button_pulse.sv
// Push-button front end: two-flop synchroniser followed by a rising-edge
// detector, producing one single-cycle pulse per press.
// The detector is only armed once the button has been seen released after
// reset, so a button held through reset does not fire on reset release.
module button_pulse (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic pulse
);

  logic sync1_r;
  logic sync2_r;
  logic settle_r;
  logic armed_r;

  // Synchroniser chain plus arming: arm only after a real (post-reset) low sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      settle_r <= 1'b0;
      armed_r  <= 1'b0;
    end else begin
      sync1_r  <= button;
      sync2_r  <= sync1_r;
      settle_r <= 1'b1;
      armed_r  <= armed_r | (settle_r & ~sync1_r);
    end
  end

  // Pulse is high for the single cycle after the first synchroniser sees the press
  assign pulse = sync1_r & ~sync2_r & armed_r;

endmodule

// File: rtl/storage_bank_sequencer.sv
// Storage bank sequencer: a DEPTH-entry byte FIFO driven from push-buttons.
// Write pushes the switches, transfer pops the oldest entry to the green LEDs,
// scan cycles the green LEDs through the stored entries without popping.
module storage_bank_sequencer
  import storage_bank_sequencer_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SCAN_PERIOD = 50_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  storage_bank_sequencer_if.slave   bus
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam int TMR_W = timer_width(SCAN_PERIOD);

  // Button pulses
  logic wr_pulse_s;
  logic tr_pulse_s;
  logic sc_pulse_s;

  // Registered state and its next values
  seq_state_e       state_r,    state_nxt_s;
  logic [LED_W-1:0] slots_r     [DEPTH];
  logic [LED_W-1:0] slots_nxt_s [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r,   wr_ptr_nxt_s;
  logic [PTR_W-1:0] rd_ptr_r,   rd_ptr_nxt_s;
  logic [CNT_W-1:0] count_r,    count_nxt_s;
  logic [PTR_W-1:0] scan_idx_r, scan_idx_nxt_s;
  logic [TMR_W-1:0] timer_r,    timer_nxt_s;
  logic [LED_W-1:0] red_r,      red_nxt_s;
  logic [LED_W-1:0] green_r,    green_nxt_s;
  logic             err_r,      err_nxt_s;

  // Decoded conditions
  logic             full_s;
  logic             empty_s;
  logic             idle_s;
  logic             scan_enter_s;
  logic             scan_fail_s;
  logic             pop_req_s;
  logic             write_ok_s;
  logic             write_fail_s;
  logic             pop_ok_s;
  logic             pop_fail_s;
  logic [PTR_W-1:0] adv_idx_s;
  logic [STATUS_W-1:0] status_s;

  button_pulse u_write_btn (
    .clk    (clk),
    .reset  (reset),
    .button (bus.write_button),
    .pulse  (wr_pulse_s)
  );

  button_pulse u_transfer_btn (
    .clk    (clk),
    .reset  (reset),
    .button (bus.transfer_button),
    .pulse  (tr_pulse_s)
  );

  button_pulse u_scan_btn (
    .clk    (clk),
    .reset  (reset),
    .button (bus.scan_button),
    .pulse  (sc_pulse_s)
  );

  // Request qualification: which of this cycle's pulses succeed or fail
  always_comb begin
    full_s       = (count_r == CNT_W'(DEPTH));
    empty_s      = (count_r == CNT_W'(0));
    idle_s       = (state_r == ST_IDLE);
    scan_enter_s = sc_pulse_s & idle_s & ~empty_s;
    scan_fail_s  = sc_pulse_s & idle_s & empty_s;
    // A transfer is ignored while scanning, including on the edge scan starts
    pop_req_s    = tr_pulse_s & idle_s & ~scan_enter_s;
    write_ok_s   = wr_pulse_s & ~full_s;
    write_fail_s = wr_pulse_s & full_s;
    pop_ok_s     = pop_req_s & ~empty_s;
    pop_fail_s   = pop_req_s & empty_s;
  end

  // Next-state logic for the FSM, bank, pointers, timer and LED registers
  always_comb begin
    state_nxt_s    = state_r;
    slots_nxt_s    = slots_r;
    wr_ptr_nxt_s   = wr_ptr_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    scan_idx_nxt_s = scan_idx_r;
    timer_nxt_s    = timer_r;
    red_nxt_s      = red_r;
    green_nxt_s    = green_r;
    err_nxt_s      = err_r;
    adv_idx_s      = scan_idx_r + PTR_W'(1);

    // Push: the pop below reads slots_r, so it always sees pre-write contents
    if (write_ok_s) begin
      slots_nxt_s[wr_ptr_r] = bus.switches;
      red_nxt_s             = bus.switches;
      wr_ptr_nxt_s          = wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (pop_ok_s) begin
      green_nxt_s  = slots_r[rd_ptr_r];
      rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    count_nxt_s = count_r + (write_ok_s ? CNT_W'(1) : CNT_W'(0))
                          - (pop_ok_s   ? CNT_W'(1) : CNT_W'(0));

    case (state_r)
      ST_IDLE: begin
        if (scan_enter_s) begin
          state_nxt_s    = ST_SCAN_SHOW;
          scan_idx_nxt_s = rd_ptr_r;
          timer_nxt_s    = TMR_W'(0);
          green_nxt_s    = slots_r[rd_ptr_r];
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SCAN_SHOW: begin
        if (sc_pulse_s) begin
          // Leaving scan freezes whatever is currently displayed
          state_nxt_s = ST_IDLE;
        end else if (timer_r == TMR_W'(SCAN_PERIOD - 1)) begin
          timer_nxt_s = TMR_W'(0);
          // Walk oldest..newest, then wrap back to the oldest entry
          if (adv_idx_s == wr_ptr_r) begin
            scan_idx_nxt_s = rd_ptr_r;
          end else begin
            scan_idx_nxt_s = adv_idx_s;
          end
          green_nxt_s = slots_r[scan_idx_nxt_s];
        end else begin
          timer_nxt_s = timer_r + TMR_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Error flag: any failed request this cycle wins over a success
    if (write_fail_s | pop_fail_s | scan_fail_s) begin
      err_nxt_s = 1'b1;
    end else if (write_ok_s | pop_ok_s | scan_enter_s) begin
      err_nxt_s = 1'b0;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        slots_r[i] <= 8'h00;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      scan_idx_r <= '0;
      timer_r    <= '0;
      red_r      <= 8'h00;
      green_r    <= 8'h00;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      slots_r    <= slots_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      scan_idx_r <= scan_idx_nxt_s;
      timer_r    <= timer_nxt_s;
      red_r      <= red_nxt_s;
      green_r    <= green_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

  // Status LED packing from registered state
  always_comb begin
    status_s               = 4'b0000;
    status_s[STATUS_ERR]   = err_r;
    status_s[STATUS_SCAN]  = (state_r == ST_SCAN_SHOW);
    status_s[STATUS_FULL]  = full_s;
    status_s[STATUS_EMPTY] = empty_s;
  end

  assign bus.red_leds    = red_r;
  assign bus.green_leds  = green_r;
  assign bus.status_leds = status_s;

  seven_segment_display u_hex0 (
    .value    (green_r[3:0]),
    .segments (bus.HEX0)
  );

  seven_segment_display u_hex1 (
    .value    (green_r[7:4]),
    .segments (bus.HEX1)
  );

endmodule

// File: tb/tb_storage_bank_sequencer.sv
// Self-checking bench for storage_bank_sequencer with a reference FIFO model
// and a scoreboard of expected {red, green, status} snapshots.
module tb_storage_bank_sequencer;

  logic clk = 1'b0;
  logic reset;

  storage_bank_sequencer_if bus ();

  storage_bank_sequencer #(
    .DEPTH       (4),
    .SCAN_PERIOD (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] m_q [$];
  logic [7:0] m_red;
  logic [7:0] m_green;
  logic       m_err;
  logic       m_scan;

  // Scoreboard: packed {red, green, status} plus a tag per entry
  logic [19:0] exp_q [$];
  string       tag_q [$];

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_C = 7'b1000110;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] model_status();
    return {m_err, m_scan, (m_q.size() == 4), (m_q.size() == 0)};
  endfunction

  task automatic push_vals(input string tag, input logic [7:0] r, input logic [7:0] g, input logic [3:0] s);
    exp_q.push_back({r, g, s});
    tag_q.push_back(tag);
  endtask

  task automatic push_model(input string tag);
    push_vals(tag, m_red, m_green, model_status());
  endtask

  task automatic check_exp();
    logic [19:0] e;
    string t;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val({t, ".red"},    {24'd0, bus.red_leds},    {24'd0, e[19:12]});
      check_val({t, ".green"},  {24'd0, bus.green_leds},  {24'd0, e[11:4]});
      check_val({t, ".status"}, {28'd0, bus.status_leds}, {28'd0, e[3:0]});
    end
  endtask

  // Non-scanning write/transfer model; the pop takes the pre-write head
  task automatic model_step(input logic w, input logic t, input logic [7:0] sw);
    logic wok, wfail, pok, pfail;
    wok   = w && (m_q.size() < 4);
    wfail = w && (m_q.size() == 4);
    pok   = t && (m_q.size() > 0);
    pfail = t && (m_q.size() == 0);
    if (pok) m_green = m_q.pop_front();
    if (wok) begin
      m_q.push_back(sw);
      m_red = sw;
    end
    if (wfail || pfail) m_err = 1'b1;
    else if (wok || pok) m_err = 1'b0;
  endtask

  // Press write and/or transfer for 'hold' cycles, then compare the result
  task automatic act(input string tag, input logic w, input logic t, input logic [7:0] sw, input int hold);
    model_step(w, t, sw);
    push_model(tag);
    bus.switches        = sw;
    bus.write_button    = w;
    bus.transfer_button = t;
    repeat (hold) @(negedge clk);
    bus.write_button    = 1'b0;
    bus.transfer_button = 1'b0;
    repeat (2) @(negedge clk);
    check_exp();
  endtask

  task automatic press_scan();
    bus.scan_button = 1'b1;
    repeat (2) @(negedge clk);
    bus.scan_button = 1'b0;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_red   = 8'h00;
    m_green = 8'h00;
    m_err   = 1'b0;
    m_scan  = 1'b0;
  endtask

  initial begin
    model_reset();
    reset               = 1'b0;
    bus.switches        = 8'h00;
    bus.write_button    = 1'b0;
    bus.transfer_button = 1'b0;
    bus.scan_button     = 1'b0;
    #12;
    check_val("reset.red",    {24'd0, bus.red_leds},    32'h00);
    check_val("reset.green",  {24'd0, bus.green_leds},  32'h00);
    check_val("reset.status", {28'd0, bus.status_leds}, 32'h1);
    check_val("reset.hex0",   {25'd0, bus.HEX0}, {25'd0, SEG_0});
    check_val("reset.hex1",   {25'd0, bus.HEX1}, {25'd0, SEG_0});
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Two writes, then drain past empty
    act("wr_a5", 1'b1, 1'b0, 8'hA5, 3);
    act("wr_3c", 1'b1, 1'b0, 8'h3C, 6);
    act("pop1",  1'b0, 1'b1, 8'h00, 3);
    act("pop2",  1'b0, 1'b1, 8'h00, 3);
    act("pop3_empty", 1'b0, 1'b1, 8'h00, 3);
    check_val("hex1_3", {25'd0, bus.HEX1}, {25'd0, SEG_3});
    check_val("hex0_c", {25'd0, bus.HEX0}, {25'd0, SEG_C});
    act("pop4_empty", 1'b0, 1'b1, 8'h00, 3);

    // Fill, overflow, pop
    for (int i = 1; i <= 4; i++) act($sformatf("fill_%0d", i), 1'b1, 1'b0, 8'(i), 3);
    act("wr_full", 1'b1, 1'b0, 8'h05, 3);
    act("pop_after_full", 1'b0, 1'b1, 8'h00, 3);
    for (int i = 0; i < 3; i++) act($sformatf("drain_%0d", i), 1'b0, 1'b1, 8'h00, 3);

    // Simultaneous write+transfer on a full bank
    for (int i = 1; i <= 4; i++) act($sformatf("refill_%0d", i), 1'b1, 1'b0, 8'(i), 3);
    act("both_full", 1'b1, 1'b1, 8'h77, 3);
    for (int i = 0; i < 3; i++) act($sformatf("drain2_%0d", i), 1'b0, 1'b1, 8'h00, 3);

    // Simultaneous on empty, then on a partly filled bank
    act("both_empty", 1'b1, 1'b1, 8'h9C, 3);
    act("both_mid",   1'b1, 1'b1, 8'h5D, 3);
    act("pop_5d",     1'b0, 1'b1, 8'h00, 3);

    // Scan on an empty bank is an error
    m_err = 1'b1;
    push_model("scan_empty");
    press_scan();
    repeat (2) @(negedge clk);
    check_exp();

    // Scan through three entries
    act("wr_11", 1'b1, 1'b0, 8'h11, 3);
    act("wr_22", 1'b1, 1'b0, 8'h22, 3);
    act("wr_33", 1'b1, 1'b0, 8'h33, 3);
    push_vals("scan_11",   8'h33, 8'h11, 4'b0100);
    push_vals("scan_22",   8'h33, 8'h22, 4'b0100);
    push_vals("scan_33",   8'h33, 8'h33, 4'b0100);
    push_vals("scan_wrap", 8'h33, 8'h11, 4'b0100);
    press_scan();
    check_exp();
    repeat (4) @(negedge clk);
    check_exp();
    bus.transfer_button = 1'b1;
    repeat (4) @(negedge clk);
    check_exp();
    bus.transfer_button = 1'b0;
    repeat (4) @(negedge clk);
    check_exp();
    m_green = 8'h11;
    push_model("scan_freeze");
    press_scan();
    repeat (6) @(negedge clk);
    check_exp();
    for (int i = 0; i < 3; i++) act($sformatf("post_scan_pop_%0d", i), 1'b0, 1'b1, 8'h00, 3);

    // Reset asynchronously mid-scan while the write button is held
    act("wr_44", 1'b1, 1'b0, 8'h44, 3);
    push_vals("scan_44", 8'h44, 8'h44, 4'b0100);
    press_scan();
    check_exp();
    bus.switches     = 8'h99;
    bus.write_button = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_val("async_rst.red",    {24'd0, bus.red_leds},    32'h00);
    check_val("async_rst.green",  {24'd0, bus.green_leds},  32'h00);
    check_val("async_rst.status", {28'd0, bus.status_leds}, 32'h1);
    check_val("async_rst.hex0",   {25'd0, bus.HEX0}, {25'd0, SEG_0});
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    push_model("held_no_pulse");
    repeat (6) @(negedge clk);
    check_exp();
    bus.write_button = 1'b0;
    repeat (3) @(negedge clk);
    act("wr_after_reset", 1'b1, 1'b0, 8'h5A, 3);
    act("pop_after_reset", 1'b0, 1'b1, 8'h00, 3);

    check_val("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
